// File: rtl/add_arb_pkg.sv
// Shared types and constants for the add_arbiter slice.
package add_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int unsigned PERF_W = 32;

  // Index width for n requesters, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add.sv
// Registered adder: out is in0+in1 (carry dropped), one cycle after the operands.
module add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    out <= in0 + in1;
  end

endmodule

// File: rtl/add_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority select, lowest index at or after ptr (wrapping).
module rr_pick
  import add_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = (32'(ptr) + off) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin sequencer sharing one registered adder among NREQ requesters.
// Optional counters perf_ops/perf_busy are built when ADD_ARB_PERF_EN is defined.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  localparam int unsigned IDW  = clog2_min1(NREQ)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*WIDTH-1:0] req_in0,
  input  logic [NREQ*WIDTH-1:0] req_in1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_data,
  output logic [IDW-1:0]    resp_id
`ifdef ADD_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_ops,
  output logic [PERF_W-1:0] perf_busy
`endif
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] op0_q;
  logic [WIDTH-1:0] op1_q;

  logic [NREQ-1:0]  pick_grant;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             accept;
  logic [IDW-1:0]   ptr_nxt;

  logic [WIDTH-1:0] in0_a [NREQ];
  logic [WIDTH-1:0] in1_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign in0_a[i] = req_in0[i*WIDTH +: WIDTH];
    assign in1_a[i] = req_in1[i*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A new op may start when idle, or when the pending result leaves this cycle.
  always_comb begin
    accept    = reset_n && pick_any &&
                ((state == IDLE) || ((state == RESP) && resp_ready));
    req_ready = accept ? pick_grant : '0;
    ptr_nxt   = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      op0_q      <= '0;
      op1_q      <= '0;
      resp_valid <= 1'b0;
    end else begin
      if (accept) begin
        op0_q  <= in0_a[pick_idx];
        op1_q  <= in1_a[pick_idx];
        id_q   <= pick_idx;
        rr_ptr <= ptr_nxt;
      end
      case (state)
        IDLE: begin
          if (accept) state <= ISSUE;
        end
        ISSUE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= accept ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_id = id_q;

  add #(.WIDTH(WIDTH)) u_add (
    .clk (clock),
    .in0 (op0_q),
    .in1 (op1_q),
    .out (resp_data)
  );

`ifdef ADD_ARB_PERF_EN
  // Saturating activity counters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (accept && (perf_ops != '1))
        perf_ops <= perf_ops + PERF_W'(1);
      if ((state != IDLE) && (perf_busy != '1))
        perf_busy <= perf_busy + PERF_W'(1);
    end
  end
`endif

endmodule
